// File: rtl/sync_ram_ctrl.sv
// rtl/sync_ram_ctrl.sv - single-port synchronous RAM with req/ready handshake, init sweep and read latency
//
// Purpose: DEPTH x DATA_WIDTH storage behind a request/ready handshake. After
// reset it sweeps zeros into every word, then reports ready and accepts one
// read or write per cycle with no back-pressure. Reads return rdata/rvalid
// RD_LATENCY (1 or 2) cycles after the accepting edge.
//
// Optional feature macro: SYNC_RAM_PARITY_EN (adds a stored even-parity bit,
// the par_inj input and the perr output).
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   req      - request, accepted on an edge where req && ready
//   wr_rd    - 0 = write, 1 = read
//   address  - word address
//   wdata    - write data
//   par_inj  - (SYNC_RAM_PARITY_EN) invert stored parity on this write
//   perr     - (SYNC_RAM_PARITY_EN) parity mismatch, qualified by rvalid
//   ready    - accepting requests (registered)
//   rdata    - read data, meaningful while rvalid = 1, held otherwise
//   rvalid   - one-cycle strobe per accepted read
module sync_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef SYNC_RAM_PARITY_EN
    input  logic                  par_inj,
    output logic                  perr,
`endif
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef SYNC_RAM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_ready;
    logic                  w_init_we;
    logic [MW-1:0]         r_mem [DEPTH];

    logic                  w_acc;
    logic                  w_rd_acc;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [MW-1:0]         w_wr_word;
    logic [MW-1:0]         w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_out_vld;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave INIT on the edge that clears the last word
    always_comb begin
        w_next_state = r_state;
        if (r_state == S_INIT && r_ptr == {ADDR_WIDTH{1'b1}}) begin
            w_next_state = S_RUN;
        end
    end

    // State outputs
    always_comb begin
        w_init_we = (r_state == S_INIT) && !rst;
    end

    // Sweep pointer and registered ready; ready rises together with RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end
            r_ready <= (w_next_state == S_RUN);
        end
    end

    // ready is only ever high in RUN, so requests during INIT are dropped here
    assign w_acc      = req && r_ready && !rst;
    assign w_rd_acc   = w_acc && wr_rd;
    assign w_mem_we   = w_init_we || (w_acc && !wr_rd);
    assign w_mem_addr = w_init_we ? r_ptr : address;

`ifdef SYNC_RAM_PARITY_EN
    assign w_wr_word = w_init_we ? '0 : {(^wdata) ^ par_inj, wdata};
`else
    assign w_wr_word = w_init_we ? '0 : wdata;
`endif

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_wr_word;
        end
    end

    assign w_rd_word = r_mem[address];
    assign w_rd_data = w_rd_word[DATA_WIDTH-1:0];

`ifdef SYNC_RAM_PARITY_EN
    logic w_rd_perr;
    logic w_out_perr;
    logic r_perr;
    assign w_rd_perr = w_rd_word[DATA_WIDTH] ^ (^w_rd_data);
`endif

    // Optional extra stage so the memory read and the output register are split
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  r_s1_vld;
            logic [DATA_WIDTH-1:0] r_s1_data;
`ifdef SYNC_RAM_PARITY_EN
            logic                  r_s1_perr;
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_data <= '0;
`ifdef SYNC_RAM_PARITY_EN
                    r_s1_perr <= 1'b0;
`endif
                end else begin
                    r_s1_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_s1_data <= w_rd_data;
                    end
`ifdef SYNC_RAM_PARITY_EN
                    r_s1_perr <= w_rd_acc && w_rd_perr;
`endif
                end
            end
            assign w_out_vld  = r_s1_vld;
            assign w_out_data = r_s1_data;
`ifdef SYNC_RAM_PARITY_EN
            assign w_out_perr = r_s1_perr;
`endif
        end else begin : g_lat1
            assign w_out_vld  = w_rd_acc;
            assign w_out_data = w_rd_data;
`ifdef SYNC_RAM_PARITY_EN
            assign w_out_perr = w_rd_perr;
`endif
        end
    endgenerate

    // Output register; rdata only loads on a valid beat so it holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
`ifdef SYNC_RAM_PARITY_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            r_rvalid <= w_out_vld;
            if (w_out_vld) begin
                r_rdata <= w_out_data;
            end
`ifdef SYNC_RAM_PARITY_EN
            r_perr   <= w_out_vld && w_out_perr;
`endif
        end
    end

    assign ready  = r_ready;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
`ifdef SYNC_RAM_PARITY_EN
    assign perr   = r_perr;
`endif

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// tb/tb_sync_ram_ctrl.sv - self-checking bench for sync_ram_ctrl at read latency 1 and 2
module tb_sync_ram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          wr_rd = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready1, ready2, rvalid1, rvalid2;
    logic [DW-1:0] rdata1, rdata2;
`ifdef SYNC_RAM_PARITY_EN
    logic          par_inj = 1'b0;
    logic          perr1, perr2;
`endif

    always #5 clk = ~clk;

    sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req), .wr_rd(wr_rd), .address(address), .wdata(wdata),
`ifdef SYNC_RAM_PARITY_EN
        .par_inj(par_inj), .perr(perr1),
`endif
        .ready(ready1), .rdata(rdata1), .rvalid(rvalid1)
    );

    sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req(req), .wr_rd(wr_rd), .address(address), .wdata(wdata),
`ifdef SYNC_RAM_PARITY_EN
        .par_inj(par_inj), .perr(perr2),
`endif
        .ready(ready2), .rdata(rdata2), .rvalid(rvalid2)
    );

    // Reference model: memory contents plus a list of read results with the
    // edge number at which each latency variant must present them.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          perr;
    } rd_ev_t;

    rd_ev_t        q1[$];
    rd_ev_t        q2[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_par [DEPTH];
    bit            m_ready = 1'b0;
    int            m_cnt = 0;
    int            n = 0;
    logic [DW-1:0] m_rdata1 = '0;
    logic [DW-1:0] m_rdata2 = '0;
    bit            m_vld1, m_vld2, m_perr1, m_perr2;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at edge %0d", tag, obs, exp, n);
        end
    endtask

    task automatic step(input bit r, input bit rq, input bit wr, input int a, input int d, input bit inj);
        bit            acc;
        rd_ev_t        ev;
        logic [DW-1:0] dv;
        dv      = DW'(d);
        rst     = r;
        req     = rq;
        wr_rd   = wr;
        address = AW'(a);
        wdata   = dv;
`ifdef SYNC_RAM_PARITY_EN
        par_inj = inj;
`endif
        acc = !r && rq && m_ready;
        @(posedge clk);
        #1;
        n++;
        if (acc && !wr) begin
            ref_mem[a] = dv;
            ref_par[a] = (^dv) ^ inj;
        end
        if (acc && wr) begin
            ev.data = ref_mem[a];
            ev.perr = ref_par[a] != (^ref_mem[a]);
            ev.due  = n;
            q1.push_back(ev);
            ev.due  = n + 1;
            q2.push_back(ev);
        end
        if (r) begin
            m_ready  = 1'b0;
            m_cnt    = 0;
            q1.delete();
            q2.delete();
            m_rdata1 = '0;
            m_rdata2 = '0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    ref_mem[i] = '0;
                    ref_par[i] = 1'b0;
                end
            end
        end
        m_vld1 = 1'b0;
        m_perr1 = 1'b0;
        if (q1.size() > 0 && q1[0].due == n) begin
            m_vld1 = 1'b1;
            m_rdata1 = q1[0].data;
            m_perr1 = q1[0].perr;
            void'(q1.pop_front());
        end
        m_vld2 = 1'b0;
        m_perr2 = 1'b0;
        if (q2.size() > 0 && q2[0].due == n) begin
            m_vld2 = 1'b1;
            m_rdata2 = q2[0].data;
            m_perr2 = q2[0].perr;
            void'(q2.pop_front());
        end
        chk("ready_l1", ready1, m_ready);
        chk("ready_l2", ready2, m_ready);
        chk("rvalid_l1", rvalid1, m_vld1);
        chk("rvalid_l2", rvalid2, m_vld2);
        chk("rdata_l1", rdata1, m_rdata1);
        chk("rdata_l2", rdata2, m_rdata2);
`ifdef SYNC_RAM_PARITY_EN
        chk("perr_l1", perr1, m_perr1);
        chk("perr_l2", perr2, m_perr2);
`endif
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic rand_ops(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_par[i] = 1'b0;
        end
        // reset values
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        // init sweep with req held high across the INIT->RUN edge
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, i, 0, 1'b0);
        // every address reads zero after the sweep
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, i, 0, 1'b0);
        idle(3);
        // back-to-back reads of fresh writes
        step(1'b0, 1'b1, 1'b0, 0, 8'h01, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1, 8'h02, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2, 8'h03, 1'b0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2, 0, 1'b0);
        idle(3);
        // read-after-write on the next cycle
        step(1'b0, 1'b1, 1'b0, 5, 8'hA5, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5, 0, 1'b0);
        idle(3);
        rand_ops(200);
        idle(3);
        // fill memory, then reset mid-sweep at ptr = 4
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, i, 8'h10 + i, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, i, 0, 1'b0);
        idle(3);
        // read in flight dropped by reset on the following edge
        step(1'b0, 1'b1, 1'b0, 3, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(DEPTH + 2);
`ifdef SYNC_RAM_PARITY_EN
        step(1'b0, 1'b1, 1'b0, 6, 8'h07, 1'b1);
        step(1'b0, 1'b1, 1'b1, 6, 0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 6, 8'h07, 1'b0);
        step(1'b0, 1'b1, 1'b1, 6, 0, 1'b0);
        idle(2);
`endif
        rand_ops(300);
        idle(DEPTH + 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_ram_ctrl.md
# sync_ram_ctrl

Parametrised single-port synchronous RAM with a request/ready handshake, configurable read latency and a self-clearing initialisation sweep after reset. It is the next generation of the team's 8x8 `wr_rd`/`address` memory. It replaces the bidirectional data bus with separate write and read data ports and adds a read-valid strobe. It sits between a bus master (CPU-side sequencer or DMA) and on-chip storage, and guarantees all-zero contents whenever it reports ready.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits (≥1)
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH words
- RD_LATENCY, 1, accept-to-rvalid latency in cycles; legal values 1 or 2

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  1  request; transfer accepted on an edge where req && ready
- wr_rd  input  1  0 = write, 1 = read (same polarity as existing memory)
- address  input  ADDR_WIDTH  word address
- wdata  input  DATA_WIDTH  write data
- ready  output  1  accepting requests (registered)
- rdata  output  DATA_WIDTH  read data, meaningful only while rvalid = 1
- rvalid  output  1  one-cycle strobe per accepted read
- par_inj  input  1  (SYNC_RAM_PARITY_EN only) invert stored parity on this write
- perr  output  1  (SYNC_RAM_PARITY_EN only) parity mismatch, qualified by rvalid

## Operation
- States: INIT, RUN. Edge with rst = 1: state ← INIT, sweep pointer ← 0, ready/rvalid/rdata/perr ← 0, read pipeline flushed.
- INIT (rst = 0): each edge writes 0 (parity 0) to mem[ptr], ptr ← ptr+1. The edge clearing ptr = DEPTH-1 moves to RUN and sets ready = 1. req is ignored in INIT.
- RUN: ready = 1 continuously. There is no back-pressure after INIT.
- Write (req, wr_rd = 0): mem[address] ← wdata on the accepting edge. No response strobe.
- Read (req, wr_rd = 1): address is sampled on the accepting edge. rdata/rvalid appear RD_LATENCY cycles later. Full throughput: one read per cycle, rvalid may stay high on consecutive cycles.
- Read data reflects every write accepted on an earlier edge. A read-after-write to the same address on the next cycle returns the new data.
- rdata holds its last value when rvalid = 0.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

## Timing
- Reset values: ready 0, rvalid 0, rdata 0, perr 0.
- Init duration: ready rises after the DEPTH-th edge with rst = 0 following reset. DEPTH = 8 gives ready high in cycle 8 after release.
- Read latency is exactly RD_LATENCY edges from the accept edge to rvalid high. RD_LATENCY = 2 adds an output register stage.
- rst asserted mid-INIT restarts the sweep from address 0.
- rst asserted with reads in flight drops them; no rvalid is issued for them.
- req held high across the INIT→RUN edge is first accepted on the edge after ready rises.

## Configuration
- Macro SYNC_RAM_PARITY_EN.
- Defined: each word stores one extra even-parity bit, ^wdata XOR par_inj. On read, perr = rvalid && (stored parity ≠ ^stored data), aligned with rvalid. INIT stores parity 0. par_inj and perr ports exist.
- Undefined: no parity storage, and the par_inj/perr ports are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset release with DEPTH = 8 → ready 0 for 8 cycles then 1. Reads of all addresses return 0x00.
- Write 0x01, 0x02, 0x03 to addresses 0, 1, 2, then read 0, 1, 2 back-to-back → rvalid high 3 consecutive cycles with data 0x01, 0x02, 0x03, RD_LATENCY cycles after each accept. Run with RD_LATENCY = 1 and 2.
- Write 0xA5 to address 5, then read address 5 on the next cycle → 0xA5.
- Assert rst for 1 cycle at sweep ptr = 4 → sweep restarts. Previously written data at addresses 0–7 reads 0 afterwards. ready delayed a full 8 cycles.
- Issue a read, then assert rst on the next edge → no rvalid. rdata = 0.
- SYNC_RAM_PARITY_EN: write 0x07 with par_inj = 1, then read → perr = 1 with rvalid. Write 0x07 with par_inj = 0, then read → perr = 0.
